// File: rtl/ak16_pkg.sv
// Shared AK-16b pipeline definitions: datapath widths, memory-stage FSM encoding
// and the default bus-wait timeout.
package ak16_pkg;
  localparam int DATA_W      = 16;
  localparam int REG_AW      = 4;
  localparam int TIMEOUT_DEF = 255;
  localparam int CNT_W       = 16;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } mem_state_e;
endpackage

// File: rtl/pipe_mem_wb.sv
// MEM/WB pipeline register. A load captures the writeback bundle; otherwise a bubble
// is inserted (write enable dropped, result and destination held).
module pipe_mem_wb #(
  parameter int DATA_W = ak16_pkg::DATA_W,
  parameter int REG_AW = ak16_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] in_result,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_reg_write,
  output logic [DATA_W-1:0] wb_result,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_reg_write
);
  import ak16_pkg::*;

  logic [DATA_W-1:0] result_d, result_q;
  logic [REG_AW-1:0] rd_d, rd_q;
  logic              reg_write_d, reg_write_q;

  always_comb begin
    result_d    = result_q;
    rd_d        = rd_q;
    reg_write_d = 1'b0;
    if (load) begin
      result_d    = in_result;
      rd_d        = in_rd;
      reg_write_d = in_reg_write;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q    <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
    end
  end

  assign wb_result    = result_q;
  assign wb_rd        = rd_q;
  assign wb_reg_write = reg_write_q;
endmodule

// File: rtl/mem_stage_ctrl.sv
// AK-16b MEM stage: runs the data-memory req/gnt/rvalid handshake for the EX/MEM bundle,
// stalls upstream while waiting, resolves branches and feeds the MEM/WB register.
module mem_stage_ctrl #(
  parameter int DATA_W  = ak16_pkg::DATA_W,
  parameter int REG_AW  = ak16_pkg::REG_AW,
  parameter int TIMEOUT = ak16_pkg::TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_rs2_data,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic              mem_mem_read,
  input  logic              mem_mem_write,
  input  logic              mem_mem_to_reg,
  input  logic              mem_branch,
  input  logic              mem_branch_ne,
  input  logic              mem_zero,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              mem_stall,
  output logic              branch_taken,
  output logic              bus_err,
  output logic [DATA_W-1:0] wb_result,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_reg_write
);
  import ak16_pkg::*;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  mem_state_e        state_d, state_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              bus_err_d, bus_err_q;
  logic              access;
  logic              req;
  logic              stall;
  logic              complete;
  logic              abort;
  logic [DATA_W-1:0] rdata_eff;
  logic [DATA_W-1:0] wb_in_result;

  assign access = mem_mem_read | mem_mem_write;

  always_comb begin
    state_d   = state_q;
    req       = 1'b0;
    complete  = 1'b0;
    abort     = 1'b0;
    rdata_eff = '0;
    case (state_q)
      IDLE: begin
        if (!access) begin
          complete = 1'b1;
        end else begin
          req = 1'b1;
          if (dmem_gnt && mem_mem_write) begin
            complete = 1'b1;
          end else if (dmem_gnt) begin
            state_d = WAIT_RSP;
          end
        end
      end
      WAIT_RSP: begin
        // rvalid is only honoured here, never in the grant cycle
        if (dmem_rvalid) begin
          complete  = 1'b1;
          rdata_eff = dmem_rdata;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    stall = ~complete;
    // Timeout forces a completion with zero read data so EX/MEM can drain
    if (stall && (cnt_q == TMO_LAST)) begin
      abort     = 1'b1;
      stall     = 1'b0;
      rdata_eff = '0;
      state_d   = IDLE;
    end

    if (!stall || ((state_q == IDLE) && (state_d == WAIT_RSP))) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    bus_err_d = abort;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign dmem_req     = req & ~rst;
  assign dmem_we      = mem_mem_write;
  assign dmem_addr    = mem_alu_result;
  assign dmem_wdata   = mem_rs2_data;
  assign mem_stall    = stall;
  assign bus_err      = bus_err_q;
  assign branch_taken = ((mem_branch & mem_zero) | (mem_branch_ne & ~mem_zero)) & ~stall;
  assign wb_in_result = mem_mem_to_reg ? rdata_eff : mem_alu_result;

  pipe_mem_wb #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_mem_wb (
    .clk          (clk),
    .rst          (rst),
    .load         (~stall),
    .in_result    (wb_in_result),
    .in_rd        (mem_rd),
    .in_reg_write (mem_reg_write),
    .wb_result    (wb_result),
    .wb_rd        (wb_rd),
    .wb_reg_write (wb_reg_write)
  );
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: vector table for single-cycle behaviour plus hand-written
// load, timeout and reset sequences; MEM/WB contents checked through a scoreboard queue.
module tb_mem_stage_ctrl;
  logic        clk;
  logic        rst;
  logic [15:0] mem_alu_result, mem_rs2_data;
  logic [3:0]  mem_rd;
  logic        mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
  logic        mem_branch, mem_branch_ne, mem_zero;
  logic        dmem_req, dmem_we;
  logic [15:0] dmem_addr, dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [15:0] dmem_rdata;
  logic        mem_stall, branch_taken, bus_err;
  logic [15:0] wb_result;
  logic [3:0]  wb_rd;
  logic        wb_reg_write;

  mem_stage_ctrl #(.DATA_W(16), .REG_AW(4), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .mem_alu_result(mem_alu_result), .mem_rs2_data(mem_rs2_data), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_branch(mem_branch), .mem_branch_ne(mem_branch_ne),
    .mem_zero(mem_zero), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .mem_stall(mem_stall), .branch_taken(branch_taken),
    .bus_err(bus_err), .wb_result(wb_result), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  rd;
    logic        rw;
  } wb_t;

  typedef struct {
    string       name;
    logic        rd_en, wr_en, br, bne, zero, gnt, m2r, rw;
    logic [15:0] alu, rs2;
    logic [3:0]  rd;
    logic        exp_req, exp_stall, exp_bt;
  } vec_t;

  vec_t vecs[$];
  wb_t  sb[$];
  wb_t  model;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_alu_result = '0; mem_rs2_data = '0; mem_rd = '0;
    mem_reg_write = 0; mem_mem_read = 0; mem_mem_write = 0; mem_mem_to_reg = 0;
    mem_branch = 0; mem_branch_ne = 0; mem_zero = 0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = '0;
  endtask

  // Push this cycle's expected MEM/WB load, clock it in, then pop and compare.
  task automatic clock_cycle(input string nm, input logic completes, input logic [15:0] res_exp);
    wb_t e, got;
    if (completes) begin
      e.res = res_exp; e.rd = mem_rd; e.rw = mem_reg_write;
      model = e;
    end else begin
      e = model; e.rw = 1'b0;
    end
    sb.push_back(e);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      chk({nm, "_wb_result"}, {16'h0, wb_result}, {16'h0, got.res});
      chk({nm, "_wb_rd"}, {28'h0, wb_rd}, {28'h0, got.rd});
      chk({nm, "_wb_reg_write"}, {31'h0, wb_reg_write}, {31'h0, got.rw});
    end
  endtask

  task automatic add_vec(input string n, input logic rd_en, input logic wr_en, input logic br,
                         input logic bne, input logic zero, input logic gnt, input logic m2r,
                         input logic rw, input logic [15:0] alu, input logic [15:0] rs2,
                         input logic [3:0] rd, input logic e_req, input logic e_stall,
                         input logic e_bt);
    vec_t v;
    v.name = n; v.rd_en = rd_en; v.wr_en = wr_en; v.br = br; v.bne = bne; v.zero = zero;
    v.gnt = gnt; v.m2r = m2r; v.rw = rw; v.alu = alu; v.rs2 = rs2; v.rd = rd;
    v.exp_req = e_req; v.exp_stall = e_stall; v.exp_bt = e_bt;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    model = '0;
    idle_inputs();
    rst = 1'b0;
    #1 rst = 1'b1;
    mem_mem_read = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_result", {16'h0, wb_result}, 32'h0);
    chk("rst_wb_rd", {28'h0, wb_rd}, 32'h0);
    chk("rst_wb_reg_write", {31'h0, wb_reg_write}, 32'h0);
    chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
    chk("rst_dmem_req", {31'h0, dmem_req}, 32'h0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    //       name            rd wr br bn z  g  m2r rw alu      rs2      rd  req stl bt
    add_vec("alu_op",        0, 0, 0, 0, 0, 0, 0,  1, 16'h1234, 16'h0,   3,  0,  0,  0);
    add_vec("alu_nowrite",   0, 0, 0, 0, 0, 0, 0,  0, 16'hFFFF, 16'h0,   15, 0,  0,  0);
    add_vec("store1",        0, 1, 0, 0, 0, 1, 0,  0, 16'h0010, 16'hA5A5, 0, 1,  0,  0);
    add_vec("store2",        0, 1, 0, 0, 0, 1, 0,  0, 16'h0011, 16'h5A5A, 0, 1,  0,  0);
    add_vec("bne_z0",        0, 0, 0, 1, 0, 0, 0,  0, 16'h0100, 16'h0,   0,  0,  0,  1);
    add_vec("beq_z0",        0, 0, 1, 0, 0, 0, 0,  0, 16'h0101, 16'h0,   0,  0,  0,  0);
    add_vec("beq_z1",        0, 0, 1, 0, 1, 0, 0,  0, 16'h0102, 16'h0,   0,  0,  0,  1);
    add_vec("bne_z1",        0, 0, 0, 1, 1, 0, 0,  0, 16'h0103, 16'h0,   0,  0,  0,  0);
    add_vec("store_nognt",   0, 1, 0, 0, 0, 0, 0,  1, 16'h0020, 16'h1111, 2, 1,  1,  0);
    add_vec("store_gnt",     0, 1, 0, 0, 0, 1, 0,  1, 16'h0020, 16'h1111, 2, 1,  0,  0);
    add_vec("beq_with_read", 1, 0, 1, 0, 1, 0, 0,  1, 16'h0030, 16'h0,   6,  1,  1,  0);
    add_vec("alu_after",     0, 0, 0, 0, 0, 0, 0,  1, 16'h0042, 16'h0,   1,  0,  0,  0);

    foreach (vecs[i]) begin
      idle_inputs();
      mem_mem_read = vecs[i].rd_en; mem_mem_write = vecs[i].wr_en;
      mem_branch = vecs[i].br; mem_branch_ne = vecs[i].bne; mem_zero = vecs[i].zero;
      dmem_gnt = vecs[i].gnt; mem_mem_to_reg = vecs[i].m2r; mem_reg_write = vecs[i].rw;
      mem_alu_result = vecs[i].alu; mem_rs2_data = vecs[i].rs2; mem_rd = vecs[i].rd;
      @(negedge clk);
      chk({vecs[i].name, "_req"}, {31'h0, dmem_req}, {31'h0, vecs[i].exp_req});
      chk({vecs[i].name, "_stall"}, {31'h0, mem_stall}, {31'h0, vecs[i].exp_stall});
      chk({vecs[i].name, "_branch"}, {31'h0, branch_taken}, {31'h0, vecs[i].exp_bt});
      if (vecs[i].exp_req) begin
        chk({vecs[i].name, "_we"}, {31'h0, dmem_we}, {31'h0, vecs[i].wr_en});
        chk({vecs[i].name, "_addr"}, {16'h0, dmem_addr}, {16'h0, vecs[i].alu});
        chk({vecs[i].name, "_wdata"}, {16'h0, dmem_wdata}, {16'h0, vecs[i].rs2});
      end
      clock_cycle(vecs[i].name, !vecs[i].exp_stall, vecs[i].m2r ? 16'h0 : vecs[i].alu);
    end

    // Load with late grant; a stray rvalid in the grant cycle must be ignored
    idle_inputs();
    mem_mem_read = 1; mem_mem_to_reg = 1; mem_reg_write = 1;
    mem_alu_result = 16'h0040; mem_rd = 4'd5;
    for (int c = 0; c < 5; c++) begin
      dmem_gnt    = (c == 2);
      dmem_rvalid = (c == 2) || (c == 4);
      dmem_rdata  = (c == 4) ? 16'hBEEF : 16'hBAD0;
      @(negedge clk);
      chk($sformatf("load_c%0d_req", c), {31'h0, dmem_req}, {31'h0, (c <= 2)});
      chk($sformatf("load_c%0d_stall", c), {31'h0, mem_stall}, {31'h0, (c < 4)});
      clock_cycle($sformatf("load_c%0d", c), (c == 4), 16'hBEEF);
    end

    // Granted read, response never arrives: abort on the fourth wait cycle
    idle_inputs();
    mem_mem_read = 1; mem_mem_to_reg = 1; mem_reg_write = 1;
    mem_alu_result = 16'h0080; mem_rd = 4'd7;
    for (int c = 0; c < 5; c++) begin
      dmem_gnt = (c == 0);
      @(negedge clk);
      chk($sformatf("tmo_c%0d_req", c), {31'h0, dmem_req}, {31'h0, (c == 0)});
      chk($sformatf("tmo_c%0d_stall", c), {31'h0, mem_stall}, {31'h0, (c < 4)});
      chk($sformatf("tmo_c%0d_bus_err", c), {31'h0, bus_err}, 32'h0);
      clock_cycle($sformatf("tmo_c%0d", c), (c == 4), 16'h0000);
    end
    idle_inputs();
    mem_alu_result = 16'h0099; mem_rd = 4'd8;
    @(negedge clk);
    chk("tmo_bus_err_pulse", {31'h0, bus_err}, 32'h1);
    clock_cycle("tmo_after", 1'b1, 16'h0099);
    @(negedge clk);
    chk("tmo_bus_err_clear", {31'h0, bus_err}, 32'h0);
    mem_mem_read = 1;
    @(negedge clk);
    chk("tmo_idle_req", {31'h0, dmem_req}, 32'h1);
    chk("tmo_idle_stall", {31'h0, mem_stall}, 32'h1);
    clock_cycle("tmo_idle", 1'b0, 16'h0);

    // Reset while waiting for read data; a late rvalid afterwards must be ignored
    idle_inputs();
    mem_mem_read = 1; mem_mem_to_reg = 1; mem_reg_write = 1;
    mem_alu_result = 16'h00C0; mem_rd = 4'd9; dmem_gnt = 1;
    @(negedge clk);
    chk("rstw_grant_req", {31'h0, dmem_req}, 32'h1);
    clock_cycle("rstw_grant", 1'b0, 16'h0);
    dmem_gnt = 0;
    @(negedge clk);
    chk("rstw_wait_req", {31'h0, dmem_req}, 32'h0);
    chk("rstw_wait_stall", {31'h0, mem_stall}, 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("rstw_wb_result", {16'h0, wb_result}, 32'h0);
    chk("rstw_wb_rd", {28'h0, wb_rd}, 32'h0);
    chk("rstw_wb_reg_write", {31'h0, wb_reg_write}, 32'h0);
    chk("rstw_dmem_req", {31'h0, dmem_req}, 32'h0);
    chk("rstw_bus_err", {31'h0, bus_err}, 32'h0);
    sb.delete();
    model = '0;
    @(posedge clk); #2;
    rst = 1'b0;
    idle_inputs();
    mem_alu_result = 16'h0055; mem_rd = 4'd4; mem_reg_write = 1;
    @(negedge clk);
    chk("rstw_post_stall", {31'h0, mem_stall}, 32'h0);
    clock_cycle("rstw_post", 1'b1, 16'h0055);
    dmem_rvalid = 1; dmem_rdata = 16'hDEAD;
    mem_alu_result = 16'h0056; mem_rd = 4'd11;
    @(negedge clk);
    chk("rstw_late_rvalid_stall", {31'h0, mem_stall}, 32'h0);
    clock_cycle("rstw_late_rvalid", 1'b1, 16'h0056);
    idle_inputs();
    mem_mem_read = 1;
    @(negedge clk);
    chk("rstw_idle_req", {31'h0, dmem_req}, 32'h1);
    clock_cycle("rstw_idle", 1'b0, 16'h0);
    idle_inputs();
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
